// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner: FSM states,
// active-low column patterns and the row/column to hex key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_t;

  localparam logic [3:0] COL_PAT_0 = 4'b1110;
  localparam logic [3:0] COL_PAT_1 = 4'b1101;
  localparam logic [3:0] COL_PAT_2 = 4'b1011;
  localparam logic [3:0] COL_PAT_3 = 4'b0111;

  function automatic logic [3:0] col_pattern(input logic [1:0] col_idx);
    case (col_idx)
      2'd0:    return COL_PAT_0;
      2'd1:    return COL_PAT_1;
      2'd2:    return COL_PAT_2;
      default: return COL_PAT_3;
    endcase
  endfunction

  // Physical keypad legend, row-major, column 0 first.
  function automatic logic [3:0] kp_decode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    case ({row_idx, col_idx})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  // Lowest-index active-low row; only meaningful when some row is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows_n);
    if (!rows_n[0])      return 2'd0;
    else if (!rows_n[1]) return 2'd1;
    else if (!rows_n[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs; resets to
// all ones so idle pulled-up lines look inactive.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks an active-low column, debounces the hit row and
// emits a one-cycle key_valid with the decoded hex key_code per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0]       rows_s;
  kp_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       col;
  logic [1:0]       row;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  // One counter serves both the column dwell and the debounce windows; the
  // cycle that first observes a new level counts as the first stable cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_SCAN;
      cnt       <= '0;
      col       <= 2'd0;
      row       <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (cnt == DWELL_LAST) begin
            if (rows_s != 4'hF) begin
              row   <= lowest_low(rows_s);
              cnt   <= CNT_ONE;
              state <= ST_PRESS_DB;
            end else begin
              cnt <= '0;
              col <= col + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_PRESS_DB: begin
          if (rows_s[row]) begin
            cnt   <= '0;
            col   <= col + 2'd1;
            state <= ST_SCAN;
          end else if (cnt == DB_LAST) begin
            key_code  <= kp_decode(row, col);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            cnt       <= '0;
            state     <= ST_HELD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (rows_s[row]) begin
            cnt   <= CNT_ONE;
            state <= ST_RELEASE_DB;
          end else begin
            cnt <= '0;
          end
        end
        ST_RELEASE_DB: begin
          if (!rows_s[row]) begin
            cnt   <= '0;
            state <= ST_HELD;
          end else if (cnt == DB_LAST) begin
            key_held <= 1'b0;
            cnt      <= '0;
            col      <= col + 2'd1;
            state    <= ST_SCAN;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_SCAN;
        end
      endcase
    end
  end

  assign cols = col_pattern(col);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8 and a
// behavioural keypad that shorts row r low while column c is driven low.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int n_checks;
  int n_fail;
  int pulses;
  int held_bad;
  logic [3:0] last_code;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses    = pulses + 1;
      last_code = key_code;
      if (!key_held) held_bad = held_bad + 1;
    end
  end

  typedef struct {
    string       name;
    logic [15:0] press;
    int          cycles;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  logic [3:0] exp_cols;
  int p0;
  int lat;
  int frozen_bad;

  initial begin
    n_checks = 0; n_fail = 0; pulses = 0; held_bad = 0; last_code = 4'h0;
    pressed = 16'h0;
    reset = 1'b1;

    vecs[0] = '{"idle",        16'h0000, 40, 0, 4'h0, 1'b0};
    vecs[1] = '{"press_r1c2",  16'h0040, 60, 1, 4'h6, 1'b1};
    vecs[2] = '{"hold_r1c2",   16'h0040, 30, 0, 4'h6, 1'b1};
    vecs[3] = '{"rel_r1c2",    16'h0000, 20, 0, 4'h6, 1'b0};
    vecs[4] = '{"dual_col0",   16'h1001, 60, 1, 4'h1, 1'b1};
    vecs[5] = '{"rel_dual",    16'h0000, 20, 0, 4'h1, 1'b0};
    vecs[6] = '{"press_r0c3",  16'h0008, 60, 1, 4'hA, 1'b1};
    vecs[7] = '{"add_r2c0",    16'h0108, 40, 0, 4'hA, 1'b1};
    vecs[8] = '{"drop_r0c3",   16'h0100, 60, 1, 4'h7, 1'b1};
    vecs[9] = '{"rel_r2c0",    16'h0000, 20, 0, 4'h7, 1'b0};

    // Reset values while reset is held
    tick(3);
    check("reset_cols", {12'h0, cols}, 16'h000E);
    check("reset_code", {12'h0, key_code}, 16'h0000);
    check("reset_valid", {15'h0, key_valid}, 16'h0000);
    check("reset_held", {15'h0, key_held}, 16'h0000);

    // Idle column walk: four cycles per column, starting at column 0
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      case ((k / 4) % 4)
        0: exp_cols = 4'b1110;
        1: exp_cols = 4'b1101;
        2: exp_cols = 4'b1011;
        default: exp_cols = 4'b0111;
      endcase
      check($sformatf("idle_cols_%0d", k), {12'h0, cols}, {12'h0, exp_cols});
      tick(1);
    end

    for (int i = 0; i < 10; i++) begin
      p0 = pulses;
      pressed = vecs[i].press;
      tick(vecs[i].cycles);
      check({vecs[i].name, "_pulses"}, 16'(pulses - p0), 16'(vecs[i].exp_pulses));
      check({vecs[i].name, "_code"}, {12'h0, key_code}, {12'h0, vecs[i].exp_code});
      check({vecs[i].name, "_held"}, {15'h0, key_held}, {15'h0, vecs[i].exp_held});
    end

    // Held key freezes the column; release latency is 2 + DEBOUNCE_CNT
    do_reset();
    p0 = pulses;
    pressed = 16'h0040;
    tick(60);
    check("hold_pulse", 16'(pulses - p0), 16'd1);
    frozen_bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (cols !== 4'b1011) frozen_bad++;
      tick(1);
    end
    check("hold_cols_frozen", 16'(frozen_bad), 16'd0);
    pressed = 16'h0000;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (!key_held) begin
        lat = k;
        break;
      end
    end
    check("release_latency", 16'(lat), 16'd10);

    // Press bounce then stable press; release bounce shorter than debounce
    do_reset();
    p0 = pulses;
    pressed = 16'h2000; tick(3);
    pressed = 16'h0000; tick(2);
    pressed = 16'h2000; tick(80);
    check("bounce_pulses", 16'(pulses - p0), 16'd1);
    check("bounce_code", {12'h0, key_code}, 16'h0000);
    check("bounce_code_at_pulse", {12'h0, last_code}, 16'h0000);
    pressed = 16'h0000; tick(4);
    pressed = 16'h2000; tick(20);
    check("rel_bounce_held", {15'h0, key_held}, 16'h0001);
    pressed = 16'h0000; tick(4);
    pressed = 16'h2000; tick(30);
    check("rel_bounce_no_repulse", 16'(pulses - p0), 16'd1);
    pressed = 16'h0000; tick(20);
    check("bounce_final_release", {15'h0, key_held}, 16'h0000);

    // Reset during PRESS_DB (column 2 dwell sampled, debounce in progress)
    do_reset();
    p0 = pulses;
    pressed = 16'h0040;
    tick(15);
    #1 reset = 1'b1;
    #1;
    check("rst_pdb_cols", {12'h0, cols}, 16'h000E);
    check("rst_pdb_held", {15'h0, key_held}, 16'h0000);
    tick(10);
    check("rst_pdb_no_pulse", 16'(pulses - p0), 16'd0);
    reset = 1'b0;
    tick(60);
    check("rst_pdb_repress", 16'(pulses - p0), 16'd1);
    check("rst_pdb_code", {12'h0, key_code}, 16'h0006);

    // Reset during HELD
    #1 reset = 1'b1;
    #1;
    check("rst_held_cols", {12'h0, cols}, 16'h000E);
    check("rst_held_code", {12'h0, key_code}, 16'h0000);
    check("rst_held_held", {15'h0, key_held}, 16'h0000);
    check("rst_held_valid", {15'h0, key_valid}, 16'h0000);
    p0 = pulses;
    tick(10);
    check("rst_held_no_pulse", 16'(pulses - p0), 16'd0);
    reset = 1'b0;
    pressed = 16'h0000;
    tick(5);

    check("valid_with_held", 16'(held_bad), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
